// File: rtl/conv_frame_encoder_if.sv
// Serial-bit in / 2-bit-symbol out bundle for the rate-1/2 frame encoder.
// The master side is the data source; the slave side is the encoder.
interface conv_frame_encoder_if;
   logic       enable_i;
   logic       d_in;
   logic       ready_o;
   logic       valid_o;
   logic [1:0] d_out;
   logic       sof_o;
   logic       eof_o;
   logic       busy_o;

   modport master (
      output enable_i, d_in,
      input  ready_o, valid_o, d_out, sof_o, eof_o, busy_o
   );

   modport slave (
      input  enable_i, d_in,
      output ready_o, valid_o, d_out, sof_o, eof_o, busy_o
   );
endinterface

// File: rtl/conv_frame_encoder.sv
// Rate-1/2 feed-forward convolutional encoder with optional K-1 zero tail
// per frame so the decoder trellis terminates in state 0.
module conv_frame_encoder #(
   parameter int           K         = 7,
   parameter logic [K-1:0] G0        = 7'b1111001,
   parameter logic [K-1:0] G1        = 7'b1011011,
   parameter int           FRAME_LEN = 256,
   parameter bit           TAIL_EN   = 1'b1
) (
   input logic                 clk,
   input logic                 rst,
   conv_frame_encoder_if.slave bus
);
   localparam int CW = $clog2(FRAME_LEN + 1);
   localparam int TW = $clog2(K);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_TAIL
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [K-2:0]  r_sr;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [TW-1:0] r_tcnt;
   logic [TW-1:0] w_tcnt_nxt;
   logic          r_valid;
   logic          r_sof;
   logic          r_eof;
   logic [1:0]    r_dout;
   logic          w_sof_nxt;
   logic          w_eof_nxt;
   logic          w_ready;
   logic          w_acc;
   logic          w_step;
   logic          w_bit;
   logic [K-1:0]  w_win;
   logic [1:0]    w_sym;

   // sr[K-2] holds the newest past bit, so the window is {b, sr}
   assign w_ready = (r_state != S_TAIL);
   assign w_acc   = bus.enable_i & w_ready;
   assign w_step  = w_acc | (r_state == S_TAIL);
   assign w_bit   = (r_state == S_TAIL) ? 1'b0 : bus.d_in;
   assign w_win   = {w_bit, r_sr};
   assign w_sym   = {^(w_win & G0), ^(w_win & G1)};

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_tcnt_nxt  = r_tcnt;
      w_sof_nxt   = 1'b0;
      w_eof_nxt   = 1'b0;
      unique case (r_state)
         S_IDLE, S_DATA: begin
            if (w_acc) begin
               w_sof_nxt   = (r_state == S_IDLE);
               w_cnt_nxt   = (r_state == S_IDLE) ?
                             CW'(1) : r_cnt + CW'(1);
               w_state_nxt = S_DATA;
               if (w_cnt_nxt == CW'(FRAME_LEN)) begin
                  w_tcnt_nxt = '0;
                  if (TAIL_EN) begin
                     w_state_nxt = S_TAIL;
                  end else begin
                     w_eof_nxt   = 1'b1;
                     w_state_nxt = S_IDLE;
                  end
               end
            end
         end
         S_TAIL: begin
            w_tcnt_nxt = r_tcnt + TW'(1);
            if (r_tcnt == TW'(K - 2)) begin
               w_eof_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_sr    <= '0;
         r_cnt   <= '0;
         r_tcnt  <= '0;
         r_valid <= 1'b0;
         r_sof   <= 1'b0;
         r_eof   <= 1'b0;
         r_dout  <= 2'b00;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_tcnt  <= w_tcnt_nxt;
         r_valid <= w_step;
         r_sof   <= w_sof_nxt;
         r_eof   <= w_eof_nxt;
         if (w_step) begin
            r_sr   <= {w_bit, r_sr[K-2:1]};
            r_dout <= w_sym;
         end
      end
   end

   assign bus.ready_o = w_ready;
   assign bus.valid_o = r_valid;
   assign bus.d_out   = r_dout;
   assign bus.sof_o   = r_sof;
   assign bus.eof_o   = r_eof;
   assign bus.busy_o  = (r_state != S_IDLE);
endmodule

// File: tb/tb_conv_frame_encoder.sv
// Scoreboard bench: two encoder instances (tail-terminated and continuous)
// checked against a stream-history reference model.
module tb_conv_frame_encoder;
   localparam int         K  = 7;
   localparam logic [6:0] G0 = 7'b1111001;
   localparam logic [6:0] G1 = 7'b1011011;

   typedef struct packed {
      int         stamp;
      logic [1:0] sym;
      logic       sof;
      logic       eof;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   conv_frame_encoder_if if0 ();
   conv_frame_encoder_if if1 ();

   conv_frame_encoder #(
      .K(K), .G0(G0), .G1(G1),
      .FRAME_LEN(4), .TAIL_EN(1'b1)
   ) dut0 (
      .clk(clk), .rst(rst), .bus(if0)
   );

   conv_frame_encoder #(
      .K(K), .G0(G0), .G1(G1),
      .FRAME_LEN(3), .TAIL_EN(1'b0)
   ) dut1 (
      .clk(clk), .rst(rst), .bus(if1)
   );

   exp_t       sbq[2][$];
   int         cyc = 0;
   int         nchk = 0;
   int         npass = 0;
   int         fl[2];
   bit         te[2];
   int         cnt[2];
   int         tl[2];
   int         slen[2];
   int         fr_exp[2];
   int         fr_seen[2];
   bit         strm[2][0:4095];
   logic [1:0] log1[$];
   bit         log_on = 1'b0;
   logic [6:0] g0v = G0;
   logic [6:0] g1v = G1;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, int act, int exp);
      nchk++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0d expected %0d at cycle %0d",
                    nm, act, exp, cyc);
   endfunction

   // Parity straight from the generator definition over the bit history
   function automatic logic [1:0] enc(int i, bit b);
      int p0 = 0;
      int p1 = 0;
      bit w;
      for (int j = 0; j < K; j++) begin
         int age = K - 1 - j;
         if (age == 0) w = b;
         else if (slen[i] - age >= 0)
            w = strm[i][(slen[i] - age) % 4096];
         else w = 1'b0;
         if (g0v[j]) p0 += int'(w);
         if (g1v[j]) p1 += int'(w);
      end
      return {p0 % 2 == 1, p1 % 2 == 1};
   endfunction

   task automatic model_step(input int i, input bit en, input bit din);
      bit   b = 1'b0;
      bit   s = 1'b0;
      bit   e = 1'b0;
      bit   st = 1'b0;
      exp_t x;
      if (tl[i] > 0) begin
         st = 1'b1;
         tl[i]--;
         e = (tl[i] == 0);
      end else if (en) begin
         st = 1'b1;
         b = din;
         s = (cnt[i] == 0);
         cnt[i]++;
         if (cnt[i] == fl[i]) begin
            cnt[i] = 0;
            if (te[i]) tl[i] = K - 1;
            else e = 1'b1;
         end
      end
      if (st) begin
         x.stamp = cyc + 1;
         x.sym   = enc(i, b);
         x.sof   = s;
         x.eof   = e;
         sbq[i].push_back(x);
         strm[i][slen[i] % 4096] = b;
         slen[i]++;
         if (e) fr_exp[i]++;
      end
   endtask

   task automatic cycle(input bit en, input bit din);
      @(negedge clk);
      chk("ready0", int'(if0.ready_o), int'(tl[0] == 0));
      chk("ready1", int'(if1.ready_o), int'(tl[1] == 0));
      chk("busy0", int'(if0.busy_o), int'(cnt[0] != 0 || tl[0] != 0));
      chk("busy1", int'(if1.busy_o), int'(cnt[1] != 0 || tl[1] != 0));
      rst = 1'b0;
      if0.enable_i = en;
      if0.d_in     = din;
      if1.enable_i = en;
      if1.d_in     = din;
      model_step(0, en, din);
      model_step(1, en, din);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      if0.enable_i = 1'b0;
      if1.enable_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cnt[i]  = 0;
         tl[i]   = 0;
         slen[i] = 0;
      end
      @(negedge clk);
      chk("rst_valid0", int'(if0.valid_o), 0);
      chk("rst_valid1", int'(if1.valid_o), 0);
      chk("rst_dout0", int'(if0.d_out), 0);
      chk("rst_sof0", int'(if0.sof_o), 0);
      chk("rst_eof0", int'(if0.eof_o), 0);
      chk("rst_busy0", int'(if0.busy_o), 0);
      chk("rst_ready0", int'(if0.ready_o), 1);
      chk("rst_busy1", int'(if1.busy_o), 0);
      chk("rst_ready1", int'(if1.ready_o), 1);
   endtask

   task automatic mon(input int i, input logic v, input logic [1:0] d,
                      input logic s, input logic e);
      exp_t x;
      if (v === 1'b1) begin
         if (sbq[i].size() == 0) begin
            chk($sformatf("unexpected_valid%0d", i), 1, 0);
         end else begin
            x = sbq[i].pop_front();
            chk($sformatf("latency%0d", i), cyc, x.stamp);
            chk($sformatf("sym%0d", i), int'(d), int'(x.sym));
            chk($sformatf("sof%0d", i), int'(s), int'(x.sof));
            chk($sformatf("eof%0d", i), int'(e), int'(x.eof));
         end
         if (e === 1'b1) fr_seen[i]++;
      end else if (v !== 1'b1 && sbq[i].size() > 0 &&
                   sbq[i][0].stamp <= cyc) begin
         x = sbq[i].pop_front();
         chk($sformatf("missing_valid%0d", i), 0, 1);
      end
   endtask

   always @(negedge clk) begin
      mon(0, if0.valid_o, if0.d_out, if0.sof_o, if0.eof_o);
      mon(1, if1.valid_o, if1.d_out, if1.sof_o, if1.eof_o);
      if (log_on && if1.valid_o === 1'b1) log1.push_back(if1.d_out);
   end

   initial begin
      logic [1:0] imp[7];
      bit         b4[4];
      int         nlow;
      imp = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
      b4  = '{1'b1, 1'b0, 1'b1, 1'b1};
      fl  = '{4, 3};
      te  = '{1'b1, 1'b0};
      fr_exp  = '{0, 0};
      fr_seen = '{0, 0};
      if0.enable_i = 1'b0;
      if0.d_in     = 1'b0;
      if1.enable_i = 1'b0;
      if1.d_in     = 1'b0;

      // Impulse response on the continuous instance
      do_reset();
      log_on = 1'b1;
      cycle(1'b1, 1'b1);
      repeat (6) cycle(1'b1, 1'b0);
      repeat (2) cycle(1'b0, 1'b0);
      log_on = 1'b0;
      chk("impulse_len", log1.size(), 7);
      for (int k = 0; k < 7; k++)
         if (k < log1.size())
            chk($sformatf("impulse%0d", k), int'(log1[k]), int'(imp[k]));

      // One terminated frame: ready low for the K-1 tail cycles
      do_reset();
      for (int k = 0; k < 4; k++) cycle(1'b1, b4[k]);
      nlow = 0;
      for (int k = 0; k < 10; k++) begin
         cycle(1'b0, 1'b0);
         if (if0.ready_o === 1'b0) nlow++;
      end
      chk("tail_ready_low", nlow, K - 1);

      // Enable gaps inside a frame
      cycle(1'b1, 1'b1);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b1);
      repeat (10) cycle(1'b0, 1'b0);

      // Enable held high through the tail, back-to-back frames
      repeat (40) cycle(1'b1, 1'($urandom_range(0, 1)));

      // Reset in the second tail cycle, then a fresh frame
      do_reset();
      for (int k = 0; k < 4; k++) cycle(1'b1, b4[k]);
      cycle(1'b0, 1'b0);
      do_reset();
      chk("midtail_valid0", int'(if0.valid_o), 0);
      for (int k = 0; k < 4; k++) cycle(1'b1, b4[k]);
      repeat (10) cycle(1'b0, 1'b0);

      // Randomized traffic with random gaps
      for (int n = 0; n < 3000; n++)
         cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));

      repeat (12) cycle(1'b0, 1'b0);
      @(negedge clk);
      chk("drain0", sbq[0].size(), 0);
      chk("drain1", sbq[1].size(), 0);
      chk("frames0", fr_seen[0], fr_exp[0]);
      chk("frames1", fr_seen[1], fr_exp[1]);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
